// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-port 256x32 data memory
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p0_stall,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = ($clog2(MAX_BURST + 1) > 3) ? $clog2(MAX_BURST + 1) : 3;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [1:0]    other_state;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          last_served;
    logic          last_next;
    logic          granted;
    logic          own_req;
    logic          own_we;
    logic          other_req;
    logic [31:0]   own_addr;
    logic [31:0]   own_wdata;
    logic          access;

    // Mux the granted port onto the memory bus.
    always_comb begin
        own_req     = 1'b0;
        own_we      = 1'b0;
        own_addr    = 32'h0;
        own_wdata   = 32'h0;
        other_req   = 1'b0;
        other_state = IDLE;
        granted     = 1'b0;
        case (state)
            GNT0: begin
                granted     = 1'b1;
                own_req     = p0_req;
                own_we      = p0_we;
                own_addr    = p0_addr;
                own_wdata   = p0_wdata;
                other_req   = p1_req;
                other_state = GNT1;
            end
            GNT1: begin
                granted     = 1'b1;
                own_req     = p1_req;
                own_we      = p1_we;
                own_addr    = p1_addr;
                own_wdata   = p1_wdata;
                other_req   = p0_req;
                other_state = GNT0;
            end
            default: ;
        endcase
    end

    // Gating with reset kills a write already on the bus in the cycle reset rises.
    assign access    = granted & own_req & ~reset;
    assign mem_re    = access & ~own_we;
    assign mem_we    = access & own_we;
    assign mem_addr  = own_addr[9:2];
    assign mem_wdata = own_wdata;

    assign p0_gnt   = (state == GNT0);
    assign p1_gnt   = (state == GNT1);
    assign p0_stall = p0_req & ~p0_gnt;

    assign cnt_inc = (burst_cnt == MAX_CNT) ? burst_cnt : burst_cnt + 1'b1;

    always_comb begin
        state_next = state;
        cnt_next   = burst_cnt;
        last_next  = last_served;
        if (granted) begin
            if (access) begin
                cnt_next = cnt_inc;
            end
            if (!own_req) begin
                state_next = other_req ? other_state : IDLE;
            end else if (cnt_inc == MAX_CNT && other_req) begin
                state_next = other_state;
            end
        end else begin
            if (p0_req && p1_req) begin
                state_next = last_served ? GNT0 : GNT1;
            end else if (p0_req) begin
                state_next = GNT0;
            end else if (p1_req) begin
                state_next = GNT1;
            end
        end
        if (state_next != state) begin
            cnt_next = '0;
            if (granted) begin
                last_next = (state == GNT1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            last_served <= 1'b1;
        end else begin
            state       <= state_next;
            burst_cnt   <= cnt_next;
            last_served <= last_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= 32'h0;
            p1_rdata  <= 32'h0;
        end else begin
            p0_rvalid <= mem_re & p0_gnt;
            p1_rvalid <= mem_re & p1_gnt;
            if (mem_re && p0_gnt) begin
                p0_rdata <= mem_rdata;
            end
            if (mem_re && p1_gnt) begin
                p1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int MAXB = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];

    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_stall, mem_re, mem_we;
    logic [31:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    bit          written [256];
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    int checks = 0;
    int failures = 0;

    int          owner;
    int          cnt;
    int          last;
    bit          erv [2];
    logic [31:0] erd [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h04) return 32'hDEADBEEF;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    always_comb mem_rdata = written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    dmem_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(rst),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p0_stall(p0_stall),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        req[0] = r0; we[0] = w0; addr[0] = a0; wdata[0] = d0;
        req[1] = r1; we[1] = w1; addr[1] = a1; wdata[1] = d1;
    endtask

    // Reference model: owner is -1 when nobody holds the memory.
    task automatic model_reset();
        owner = -1;
        cnt = 0;
        last = 1;
        erv[0] = 1'b0; erv[1] = 1'b0;
        erd[0] = 32'h0; erd[1] = 32'h0;
    endtask

    task automatic check_model();
        bit acc;
        int n;
        if (rst) model_reset();
        n = owner;
        acc = (owner >= 0) && req[owner];
        chk1("gnt0", p0_gnt, owner == 0);
        chk1("gnt1", p1_gnt, owner == 1);
        chk1("stall0", p0_stall, req[0] && owner != 0);
        chk1("mem_re", mem_re, acc && !we[n]);
        chk1("mem_we", mem_we, acc && we[n]);
        if (acc) chk32("mem_addr", {24'h0, mem_addr}, {24'h0, addr[n][9:2]});
        if (acc && we[n]) chk32("mem_wdata", mem_wdata, wdata[n]);
        chk1("rvalid0", p0_rvalid, erv[0]);
        chk1("rvalid1", p1_rvalid, erv[1]);
        chk32("rdata0", p0_rdata, erd[0]);
        chk32("rdata1", p1_rdata, erd[1]);
        chk1("one_gnt", p0_gnt & p1_gnt, 1'b0);
        chk1("re_we_excl", mem_re & mem_we, 1'b0);
    endtask

    task automatic model_step();
        bit acc;
        int n;
        int o;
        if (rst) begin
            model_reset();
            return;
        end
        erv[0] = 1'b0; erv[1] = 1'b0;
        if (owner < 0) begin
            if (req[0] && req[1]) owner = 1 - last;
            else if (req[0]) owner = 0;
            else if (req[1]) owner = 1;
            cnt = 0;
            return;
        end
        n = owner;
        o = 1 - n;
        acc = req[n];
        if (acc) begin
            if (cnt < MAXB) cnt = cnt + 1;
            if (we[n]) ref_mem[addr[n][9:2]] = wdata[n];
            else begin
                erv[n] = 1'b1;
                erd[n] = ref_mem[addr[n][9:2]];
            end
        end
        if (!req[n]) begin
            last = n;
            owner = req[o] ? o : -1;
            cnt = 0;
        end else if (cnt == MAXB && req[o]) begin
            last = n;
            owner = o;
            cnt = 0;
        end
    endtask

    task automatic finish_cycle();
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run_cycle();
        #4;
        finish_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0);
        run_cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic r0, w0; logic [31:0] a0, d0;
        logic r1, w1; logic [31:0] a1, d1;
        logic g0, g1, re, wr; logic [7:0] ma;
        logic rv0, rv1; logic [31:0] rd;
    } vec_t;

    vec_t tbl [8];
    int   exp_owner;
    int   drop_owner [9] = '{-1, 0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        tbl[0] = '{H, L, 32'h10, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L, 8'h00, L, L, 32'h0};
        tbl[1] = '{H, L, 32'h10, 32'h0, L, L, 32'h0, 32'h0, H, L, H, L, 8'h04, L, L, 32'h0};
        tbl[2] = '{L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, H, L, L, L, 8'h00, H, L, 32'hDEADBEEF};
        tbl[3] = '{L, L, 32'h0, 32'h0, H, H, 32'h3FC, 32'h12345678, L, L, L, L, 8'h00, L, L, 32'h0};
        tbl[4] = '{L, L, 32'h0, 32'h0, H, H, 32'h3FC, 32'h12345678, L, H, L, H, 8'hFF, L, L, 32'h0};
        tbl[5] = '{L, L, 32'h0, 32'h0, H, L, 32'h3FC, 32'h0, L, H, H, L, 8'hFF, L, L, 32'h0};
        tbl[6] = '{L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, H, L, L, 8'h00, L, H, 32'h12345678};
        tbl[7] = '{L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0, L, L, L, L, 8'h00, L, L, 32'h0};

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        model_reset();

        rst = 1'b1;
        drive(L, L, 32'h0, 32'h0, L, L, 32'h0, 32'h0);
        @(negedge clk);
        #4;
        chk1("rst_gnt0", p0_gnt, 1'b0);
        chk1("rst_gnt1", p1_gnt, 1'b0);
        chk1("rst_rvalid0", p0_rvalid, 1'b0);
        chk32("rst_rdata1", p1_rdata, 32'h0);
        chk1("rst_mem_re", mem_re, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single read, write-then-read on port 1 at the top word.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            #4;
            chk1($sformatf("tbl%0d_gnt0", i), p0_gnt, tbl[i].g0);
            chk1($sformatf("tbl%0d_gnt1", i), p1_gnt, tbl[i].g1);
            chk1($sformatf("tbl%0d_mem_re", i), mem_re, tbl[i].re);
            chk1($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].wr);
            if (tbl[i].re || tbl[i].wr) chk32($sformatf("tbl%0d_mem_addr", i), {24'h0, mem_addr}, {24'h0, tbl[i].ma});
            chk1($sformatf("tbl%0d_rvalid0", i), p0_rvalid, tbl[i].rv0);
            chk1($sformatf("tbl%0d_rvalid1", i), p1_rvalid, tbl[i].rv1);
            if (tbl[i].rv0) chk32($sformatf("tbl%0d_rdata0", i), p0_rdata, tbl[i].rd);
            if (tbl[i].rv1) chk32($sformatf("tbl%0d_rdata1", i), p1_rdata, tbl[i].rd);
            @(posedge clk);
            @(negedge clk);
        end
        ref_mem[8'hFF] = 32'h12345678;

        // Tie after reset, then continuous contention alternates in bursts of MAXB.
        do_reset();
        for (int c = 0; c < 18; c++) begin
            drive(H, L, $urandom, 32'h0, H, L, $urandom, 32'h0);
            exp_owner = (c == 0) ? -1 : ((c - 1) / MAXB) % 2;
            #4;
            chk1($sformatf("burst%0d_gnt0", c), p0_gnt, exp_owner == 0);
            chk1($sformatf("burst%0d_gnt1", c), p1_gnt, exp_owner == 1);
            chk1($sformatf("burst%0d_stall0", c), p0_stall, exp_owner != 0);
            finish_cycle();
        end

        // Port 0 drops after two accesses; port 1 then gets a full fresh burst.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(c != 3, L, $urandom, 32'h0, H, L, $urandom, 32'h0);
            #4;
            chk1($sformatf("drop%0d_gnt0", c), p0_gnt, drop_owner[c] == 0);
            chk1($sformatf("drop%0d_gnt1", c), p1_gnt, drop_owner[c] == 1);
            finish_cycle();
        end

        // Reset raised in the middle of a granted write.
        do_reset();
        drive(H, H, 32'h20, 32'hA5A5A5A5, L, L, 32'h0, 32'h0);
        run_cycle();
        #2;
        chk1("pre_rst_mem_we", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        chk1("midrst_mem_we", mem_we, 1'b0);
        chk1("midrst_mem_re", mem_re, 1'b0);
        chk1("midrst_gnt0", p0_gnt, 1'b0);
        chk1("midrst_rvalid0", p0_rvalid, 1'b0);
        #1;
        finish_cycle();
        chk32("midrst_mem_untouched", written[8'h08] ? mem[8'h08] : init_val(8'h08), ref_mem[8'h08]);
        rst = 1'b0;
        drive(H, L, 32'h0, 32'h0, H, L, 32'h4, 32'h0);
        run_cycle();
        #4;
        chk1("tie_after_midrst_gnt0", p0_gnt, 1'b1);
        finish_cycle();

        // Randomized traffic with sticky requests and occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) == 0) req[p] = ~req[p];
                we[p] = ($urandom_range(0, 2) == 0);
                addr[p] = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 7)) << 2);
                wdata[p] = $urandom;
            end
            rst = ($urandom_range(0, 199) == 0);
            run_cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: maximum consecutive accesses one port may hold while the other port waits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports p0_req, p0_we (inputs, 1 bit each): port 0 (pipeline MEM stage) access request and write select.
REQ-005 SHALL have ports p0_addr, p0_wdata (inputs, 32 bits each): port 0 byte address and write data.
REQ-006 SHALL have ports p0_gnt, p0_rvalid (outputs, 1 bit each) and p0_rdata (output, 32 bits): port 0 grant, read-valid and read data.
REQ-007 SHALL have the same p1_* set as REQ-004..006 for port 1 (DMA/debug loader).
REQ-008 SHALL have output p0_stall, 1 bit: p0_req AND NOT p0_gnt, combinational, for freezing the pipeline.
REQ-009 SHALL have outputs mem_re and mem_we (1 bit each), mem_addr (8 bits) and mem_wdata (32 bits), plus input mem_rdata (32 bits): single-port 256x32 memory, combinational read, synchronous write.

Function
REQ-010 SHALL implement FSM states IDLE, GNT0 and GNT1; gnt_n = 1 exactly when state = GNTn.
REQ-011 SHALL, in GNTn with pn_req = 1, perform one access that cycle: mem_addr = pn_addr[9:2]; mem_wdata = pn_wdata; mem_we = pn_we; mem_re = NOT pn_we.
REQ-012 SHALL drive mem_re = mem_we = 0 in IDLE, and in GNTn while pn_req = 0.
REQ-013 SHALL ignore address bits [1:0] and [31:10]; there is no misalignment or range error.
REQ-014 SHALL register read results: a read in cycle k gives pn_rvalid = 1 and pn_rdata = mem_rdata in cycle k+1 only. pn_rvalid SHALL be 0 after writes and idle cycles; pn_rdata SHALL hold its last value otherwise.
REQ-015 SHALL give a 1-cycle grant latency: pn_req rising in IDLE at cycle k gives gnt_n = 1 and the first access at k+1.
REQ-016 SHALL, in IDLE with both requests set, grant the port not in last_served. last_served resets to 1, so port 0 wins the first tie.
REQ-017 SHALL count accesses in a 3-bit-or-wider burst_cnt. It clears on every grant change and increments by 1 per performed access, saturating at MAX_BURST.
REQ-018 SHALL apply these transitions from GNTn:
- pn_req = 0 and other req = 1 -> GNT(other).
- pn_req = 0 and other req = 0 -> IDLE.
- burst_cnt reaches MAX_BURST on this access and other req = 1 -> GNT(other).
- Otherwise stay in GNTn.
REQ-019 SHALL set last_served = n when leaving GNTn.
REQ-020 SHALL hand over back-to-back: there is no IDLE bubble between GNT0 and GNT1.
REQ-021 SHALL let a sole requester hold its grant indefinitely; burst_cnt saturates and causes no forced release.
REQ-022 SHALL never assert both grants, and never assert both mem_re and mem_we.

Reset
REQ-023 SHALL, while reset = 1, immediately force: state = IDLE, gnts = 0, rvalids = 0, rdata = 0, burst_cnt = 0, last_served = 1, and mem_re = mem_we = 0.
REQ-024 SHALL, when reset is asserted mid-access, suppress mem_we in that same cycle, and SHALL not produce rvalid for a read in flight.
REQ-025 SHALL, on the first rising edge after reset deassertion with a request pending, behave as in REQ-015.

Verification
REQ-026 Single read: p0 read, addr 0x10, with mem word 4 = 0xDEADBEEF -> p0_gnt at k+1, mem_addr = 0x04, mem_re = 1; p0_rvalid = 1, p0_rdata = 0xDEADBEEF at k+2.
REQ-027 Tie after reset: p0_req = p1_req = 1 at the same edge -> GNT0 first.
REQ-028 Burst fairness: both ports hold req continuously (MAX_BURST = 4) -> p0 performs exactly 4 accesses, then GNT1 with no idle cycle, then 4 more accesses, alternating. p0_stall = 1 during GNT1.
REQ-029 Handover on drop: p1 holds req while p0 drops req after 2 accesses -> GNT1 the next cycle; burst_cnt = 0.
REQ-030 Write then read: p1 writes 0x12345678 to addr 0x3FC, then reads it -> mem_addr = 0xFF, mem_we = 1 for one cycle; read returns 0x12345678; p1_rvalid = 0 after the write.
REQ-031 Reset mid-burst: reset asserted during a GNT0 write -> mem_we = 0 in that cycle, all outputs 0, IDLE; the next tie is granted to port 0.
